// File: rtl/ct_l2c_data_sram_ctrl_pkg.sv
// Shared definitions for the L2C data SRAM controller: read latency and default sizes.
// The latency follows CT_L2C_SRAM_QREG_EN (adds a Q register stage when defined).
package ct_l2c_data_sram_ctrl_pkg;

`ifdef CT_L2C_SRAM_QREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 144;
  localparam int DEF_RSP_DEPTH  = 2;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ct_l2c_data_sram_ctrl_if.sv
// Request, response and SRAM macro pin bundle for the L2C data SRAM controller.
// slave = the controller, master = the pipeline/SRAM side driving it.
interface ct_l2c_data_sram_ctrl_if
  import ct_l2c_data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_bmask;

  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_bmask, sram_q, rsp_rdy,
    output req_rdy, sram_a, sram_cen, sram_gwen, sram_wen, sram_d, rsp_vld, rsp_data
  );

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_bmask, sram_q, rsp_rdy,
    input  req_rdy, sram_a, sram_cen, sram_gwen, sram_wen, sram_d, rsp_vld, rsp_data
  );
endinterface

// File: rtl/ct_l2c_sram_rsp_fifo.sv
// Circular read-response FIFO with wrapping pointers. First-word fall-through:
// a push into an empty FIFO is visible (and poppable) in the same cycle.
module ct_l2c_sram_rsp_fifo
  import ct_l2c_data_sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] data
);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = cnt_width(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);

  logic [DATA_WIDTH-1:0] mem_reg [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  do_pop;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == CNT_FULL);
  assign vld    = !empty || push;
  assign data   = empty ? push_data : mem_reg[rd_ptr_reg];
  assign do_pop = pop && vld;

  // A pass-through (empty, push and pop together) still writes the slot and
  // advances both pointers, which leaves the FIFO empty as required.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push)
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    if (do_pop)
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    case ({push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_reg[wr_ptr_reg] <= push_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/ct_l2c_data_sram_ctrl.sv
// Request/response front end for one single-port L2C data SRAM macro (active-low pins).
// Optional Q register stage before the response FIFO: CT_L2C_SRAM_QREG_EN.
module ct_l2c_data_sram_ctrl
  import ct_l2c_data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
)
(
  input  logic                   forever_cpuclk,
  input  logic                   cpurst,
  ct_l2c_data_sram_ctrl_if.slave bus
);
  localparam int CNT_W = cnt_width(RSP_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_DEPTH);

  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  acc, rd_acc, wr_acc, rsp_pop;
  logic [ADDR_WIDTH-1:0] a_shadow_reg;
  logic [DATA_WIDTH-1:0] d_shadow_reg;
  logic [LAT-1:0]        vld_pipe_reg;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  fifo_full, fifo_empty;

  // Credits cover every in-flight pipeline stage plus FIFO occupancy, so a read
  // is only taken when its response is guaranteed a slot.
  assign bus.req_rdy = bus.req_wr || (cnt_reg < CNT_MAX);
  assign acc         = bus.req_vld && bus.req_rdy;
  assign rd_acc      = acc && !bus.req_wr;
  assign wr_acc      = acc && bus.req_wr;
  assign rsp_pop     = bus.rsp_vld && bus.rsp_rdy;

  // Address and data hold their previous value when idle to avoid toggling the macro inputs.
  always_comb begin
    bus.sram_cen  = 1'b1;
    bus.sram_gwen = 1'b1;
    bus.sram_wen  = '1;
    bus.sram_a    = a_shadow_reg;
    bus.sram_d    = d_shadow_reg;
    if (acc) begin
      bus.sram_cen = 1'b0;
      bus.sram_a   = bus.req_addr;
      if (bus.req_wr) begin
        bus.sram_gwen = 1'b0;
        bus.sram_wen  = ~bus.req_bmask;
        bus.sram_d    = bus.req_wdata;
      end
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({rd_acc, rsp_pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      cnt_reg      <= '0;
      a_shadow_reg <= '0;
      d_shadow_reg <= '0;
      vld_pipe_reg <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      vld_pipe_reg <= LAT'({vld_pipe_reg, rd_acc});
      if (acc)
        a_shadow_reg <= bus.req_addr;
      if (wr_acc)
        d_shadow_reg <= bus.req_wdata;
    end
  end

  // Bit 0 marks the cycle in which the macro's Q holds a requested word.
  assign push = vld_pipe_reg[LAT-1];

`ifdef CT_L2C_SRAM_QREG_EN
  logic [DATA_WIDTH-1:0] q_reg;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst)
      q_reg <= '0;
    else if (vld_pipe_reg[0])
      q_reg <= bus.sram_q;
  end

  assign push_data = q_reg;
`else
  assign push_data = bus.sram_q;
`endif

  ct_l2c_sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (forever_cpuclk),
    .rst       (cpurst),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.rsp_rdy),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .vld       (bus.rsp_vld),
    .data      (bus.rsp_data)
  );

  credit_vs_empty: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    fifo_empty || (cnt_reg != '0));
  credit_vs_full: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    !fifo_full || (cnt_reg == CNT_MAX));

endmodule
